reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_DOM, default 4: number of downstream reset domains (2..8).
REQ-002 Parameter LOCK_FILTER, default 256: consecutive synchronized pll_locked-high cycles required before release.
REQ-003 Parameter GAP_CYCLES, default 1024: clk_50 cycles between successive domain releases (>=1).
REQ-004 Parameter SW_HOLD, default 16: cycles all domains are held after a software reset request (>=1).
REQ-005 clk_50  input  1  sole clock, 50 MHz, from the external oscillator.
REQ-006 por_reset_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk_50.
REQ-007 pll_locked  input  1  PLL lock indicator, asynchronous to clk_50.
REQ-008 sw_reset_req  input  1  single-cycle software reset request, synchronous to clk_50.
REQ-009 dom_rst_n  output  N_DOM  per-domain active-low resets, registered; bit 0 is released first.
REQ-010 seq_done  output  1  high while all domains are released (RUN state), registered.
REQ-011 seq_state  output  3  current FSM state code, for debug.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer (lock_s) before any use; all latencies below are measured from lock_s.
REQ-013 FSM states and codes SHALL be: HOLD=0, LOCK_WAIT=1, RELEASE=2, RUN=3, SW_HOLD=4; unused codes SHALL return to HOLD on the next edge.
REQ-014 HOLD: all dom_rst_n low and seq_done low; go to LOCK_WAIT on the next edge unconditionally.
REQ-015 LOCK_WAIT: lock_cnt increments each edge lock_s=1 and clears to 0 on any edge lock_s=0.
REQ-016 LOCK_WAIT: on the edge lock_cnt reaches LOCK_FILTER, go to RELEASE, clear gap_cnt, and drive dom_rst_n[0] high on that same edge.
REQ-017 RELEASE: gap_cnt counts 0..GAP_CYCLES-1. At terminal count, release the next unreleased domain in ascending index order and clear gap_cnt.
REQ-018 RELEASE: on the edge the last domain (N_DOM-1) is released, go to RUN and set seq_done high on that same edge.
REQ-019 Released domains SHALL stay released until a lock-loss or software reset event; no output bit SHALL ever glitch between edges.
REQ-020 Lock loss: lock_s=0 in RELEASE, RUN or SW_HOLD SHALL, on that edge:
  - drive all dom_rst_n low and seq_done low;
  - clear all counters;
  - go to LOCK_WAIT.
REQ-021 sw_reset_req=1 in RELEASE or RUN SHALL, on that edge:
  - drive all dom_rst_n low and seq_done low;
  - clear hold_cnt;
  - go to SW_HOLD.
REQ-022 sw_reset_req SHALL be ignored in HOLD, LOCK_WAIT and SW_HOLD; it does not extend the hold.
REQ-023 SW_HOLD: after SW_HOLD cycles, go to RELEASE with the REQ-016 behaviour (dom_rst_n[0] released on the exit edge); the lock filter is not re-run.
REQ-024 If lock loss and sw_reset_req occur on the same edge, lock loss SHALL win (LOCK_WAIT).
REQ-025 Each counter SHALL be sized $clog2(limit+1) bits and SHALL saturate and never wrap.

Reset
REQ-026 While por_reset_n=0: state=HOLD, dom_rst_n all 0, seq_done=0, all counters 0, synchronizer flops 0.
REQ-027 Asserting por_reset_n mid-sequence SHALL force REQ-026 values immediately, without waiting for a clock edge.

Verification
(All scenarios use N_DOM=4, LOCK_FILTER=8, GAP_CYCLES=4, SW_HOLD=3. Edge 1 = first clk_50 rising edge after por_reset_n rises.)
REQ-028 Cold start: pll_locked=1 throughout -> dom_rst_n[0] rises at edge 10, [1] at 14, [2] at 18, [3] at 22; seq_done rises at 22.
REQ-029 Lock chatter: pll_locked low for 1 cycle at lock_cnt=5 -> lock_cnt clears; dom_rst_n[0] is released 8 lock_s-high edges after recovery.
REQ-030 Lock loss in RUN: lock_s falls -> dom_rst_n=4'b0000 and seq_done=0 on that edge; state=1; the full sequence repeats after re-lock.
REQ-031 Software reset in RUN: sw_reset_req pulse at edge E -> dom_rst_n=0 at E; dom_rst_n[0] at E+3, [1] at E+7, [3] and seq_done at E+15.
REQ-032 Simultaneous lock loss and sw_reset_req in RELEASE -> state=LOCK_WAIT (code 1), not SW_HOLD. A second sw_reset_req during SW_HOLD does not shift the release edge.
REQ-033 Async reset mid-RELEASE: por_reset_n pulled low between edges -> all outputs 0 before the next edge; the cold-start timing of REQ-028 recurs after release.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the sequencer's control and status signals.
//   pll_locked   : PLL lock indicator (asynchronous to clk_50)
//   sw_reset_req : single-cycle software reset request (synchronous to clk_50)
//   dom_rst_n    : per-domain active-low resets, bit 0 released first
//   seq_done     : high while every domain is released
//   seq_state    : current sequencer state code, for debug
// The master modport is the sequencer itself; the slave modport is the
// surrounding system that supplies lock/request and consumes the resets.
// ----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int N_DOM = 4
);
    logic             pll_locked;
    logic             sw_reset_req;
    logic [N_DOM-1:0] dom_rst_n;
    logic             seq_done;
    logic [2:0]       seq_state;

    modport master (
        input  pll_locked,
        input  sw_reset_req,
        output dom_rst_n,
        output seq_done,
        output seq_state
    );

    modport slave (
        output pll_locked,
        output sw_reset_req,
        input  dom_rst_n,
        input  seq_done,
        input  seq_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
// Holds N_DOM downstream reset domains in reset until the PLL has been
// stably locked for LOCK_FILTER cycles, then releases the domains one at a
// time, GAP_CYCLES apart, in ascending index order. Loss of lock drops every
// domain and restarts the lock filter; a software request drops every domain
// for SW_HOLD cycles and then re-runs the staggered release without
// re-filtering the lock.
// Ports:
//   clk_50      : sole clock (50 MHz)
//   por_reset_n : asynchronous active-low power-on reset
//   seq_if      : reset_sequencer_if.master (pll_locked, sw_reset_req in;
//                 dom_rst_n, seq_done, seq_state out)
// ----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_DOM       = 4,
    parameter int LOCK_FILTER = 256,
    parameter int GAP_CYCLES  = 1024,
    parameter int SW_HOLD     = 16
) (
    input  logic              clk_50,
    input  logic              por_reset_n,
    reset_sequencer_if.master seq_if
);

    localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int HOLD_W = $clog2(SW_HOLD + 1);

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FILTER);
    localparam logic [N_DOM-1:0]  DOM0_ONLY = {{(N_DOM-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic              sync1_q,     sync1_d;
    logic              lock_s_q,    lock_s_d;
    logic [LOCK_W-1:0] lock_cnt_q,  lock_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [N_DOM-1:0]  dom_rst_n_q, dom_rst_n_d;
    logic              seq_done_q,  seq_done_d;

    // Next-state logic. Every output is computed here and registered below,
    // so the domain resets can only change on a clock edge (or on POR).
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        dom_rst_n_d = dom_rst_n_q;
        seq_done_d  = seq_done_q;

        // Two-flop synchronizer: only lock_s_q is used by the FSM.
        sync1_d  = seq_if.pll_locked;
        lock_s_d = sync1_q;

        case (state_q)
            ST_HOLD: begin
                state_d     = ST_LOCK_WAIT;
                lock_cnt_d  = '0;
                gap_cnt_d   = '0;
                hold_cnt_d  = '0;
                dom_rst_n_d = '0;
                seq_done_d  = 1'b0;
            end

            ST_LOCK_WAIT: begin
                dom_rst_n_d = '0;
                seq_done_d  = 1'b0;
                if (!lock_s_q) begin
                    lock_cnt_d = '0;
                end else if (int'(lock_cnt_q) + 1 >= LOCK_FILTER) begin
                    // Filter satisfied on this edge: domain 0 leaves reset now.
                    lock_cnt_d  = LOCK_MAX;
                    gap_cnt_d   = '0;
                    dom_rst_n_d = DOM0_ONLY;
                    state_d     = ST_RELEASE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!lock_s_q) begin
                    // Lock loss outranks a simultaneous software request.
                    state_d     = ST_LOCK_WAIT;
                    lock_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    dom_rst_n_d = '0;
                    seq_done_d  = 1'b0;
                end else if (seq_if.sw_reset_req) begin
                    state_d     = ST_SW_HOLD;
                    gap_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    dom_rst_n_d = '0;
                    seq_done_d  = 1'b0;
                end else if (state_q == ST_RELEASE) begin
                    if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
                        // Released domains form a thermometer code from bit 0,
                        // so shifting in a one releases the next index.
                        gap_cnt_d   = '0;
                        dom_rst_n_d = {dom_rst_n_q[N_DOM-2:0], 1'b1};
                        if (dom_rst_n_q[N_DOM-2]) begin
                            state_d    = ST_RUN;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end

            ST_SW_HOLD: begin
                dom_rst_n_d = '0;
                seq_done_d  = 1'b0;
                if (!lock_s_q) begin
                    state_d    = ST_LOCK_WAIT;
                    lock_cnt_d = '0;
                    gap_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (int'(hold_cnt_q) + 1 >= SW_HOLD) begin
                    // Hold complete: restart the staggered release directly,
                    // the PLL has stayed locked throughout.
                    state_d     = ST_RELEASE;
                    hold_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    dom_rst_n_d = DOM0_ONLY;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d     = ST_HOLD;
                lock_cnt_d  = '0;
                gap_cnt_d   = '0;
                hold_cnt_d  = '0;
                dom_rst_n_d = '0;
                seq_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge por_reset_n) begin
        if (!por_reset_n) begin
            state_q     <= ST_HOLD;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            dom_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            lock_cnt_q  <= lock_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            dom_rst_n_q <= dom_rst_n_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign seq_if.dom_rst_n = dom_rst_n_q;
    assign seq_if.seq_done  = seq_done_q;
    assign seq_if.seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed scenarios followed by a randomized lock/request run, all checked
// against a timestamp-based reference model of the release schedule.
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N_DOM       = 4;
    localparam int LOCK_FILTER = 8;
    localparam int GAP_CYCLES  = 4;
    localparam int SW_HOLD     = 3;

    logic clk_50 = 1'b0;
    logic por_reset_n;

    reset_sequencer_if #(.N_DOM(N_DOM)) bus ();

    reset_sequencer #(
        .N_DOM      (N_DOM),
        .LOCK_FILTER(LOCK_FILTER),
        .GAP_CYCLES (GAP_CYCLES),
        .SW_HOLD    (SW_HOLD)
    ) dut (
        .clk_50     (clk_50),
        .por_reset_n(por_reset_n),
        .seq_if     (bus)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Reference model: phase code, consecutive synchronized-lock edges,
    // edge counter since POR and the edge at which the current release
    // (or software hold) began. Released domains follow from elapsed time.
    int m_phase;
    int m_run;
    int m_edge;
    int m_t0;
    bit m_h1;
    bit m_h2;

    function automatic int releasedNow();
        int n;
        n = 1 + (m_edge - m_t0) / GAP_CYCLES;
        return (n > N_DOM) ? N_DOM : n;
    endfunction

    task automatic modelReset();
        m_phase = 0;
        m_run   = 0;
        m_edge  = 0;
        m_t0    = 0;
        m_h1    = 1'b0;
        m_h2    = 1'b0;
    endtask

    task automatic modelStep(input bit pll, input bit sw);
        bit ls;
        ls = m_h2;
        m_edge++;
        case (m_phase)
            0: begin
                m_phase = 1;
                m_run   = 0;
            end
            1: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == LOCK_FILTER) begin
                    m_phase = 2;
                    m_t0    = m_edge;
                end
            end
            2, 3: begin
                if (!ls) begin
                    m_phase = 1;
                    m_run   = 0;
                end else if (sw) begin
                    m_phase = 4;
                    m_t0    = m_edge;
                end else if (releasedNow() == N_DOM) begin
                    m_phase = 3;
                end
            end
            4: begin
                if (!ls) begin
                    m_phase = 1;
                    m_run   = 0;
                end else if (m_edge - m_t0 == SW_HOLD) begin
                    m_phase = 2;
                    m_t0    = m_edge;
                end
            end
            default: m_phase = 0;
        endcase
        m_h2 = m_h1;
        m_h1 = pll;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int exp_dom;
        exp_dom = (m_phase == 2 || m_phase == 3) ? ((1 << releasedNow()) - 1) : 0;
        checkValue($sformatf("dom_rst_n@%0d", m_edge), 32'(bus.dom_rst_n), 32'(exp_dom));
        checkValue($sformatf("seq_done@%0d", m_edge), 32'(bus.seq_done), 32'(m_phase == 3));
        checkValue($sformatf("seq_state@%0d", m_edge), 32'(bus.seq_state), 32'(m_phase));
    endtask

    task automatic checkZeros(input string tag);
        checkValue({tag, " dom_rst_n"}, 32'(bus.dom_rst_n), 32'h0);
        checkValue({tag, " seq_done"}, 32'(bus.seq_done), 32'h0);
        checkValue({tag, " seq_state"}, 32'(bus.seq_state), 32'h0);
    endtask

    // Drive inputs after a falling edge, let one rising edge consume them,
    // then compare on the following falling edge.
    task automatic applyStimulus(input bit pll, input bit sw);
        bus.pll_locked   = pll;
        bus.sw_reset_req = sw;
        @(posedge clk_50);
        @(negedge clk_50);
        bus.sw_reset_req = 1'b0;
        modelStep(pll, sw);
        checkOutput();
    endtask

    // Power-on reset pulse; must be entered between rising edges.
    task automatic porPulse(input string tag);
        por_reset_n = 1'b0;
        #1;
        checkZeros({tag, " immediate"});
        modelReset();
        @(negedge clk_50);
        @(negedge clk_50);
        checkZeros({tag, " held"});
        por_reset_n = 1'b1;
    endtask

    initial begin
        por_reset_n      = 1'b0;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        modelReset();

        $display("[TB] cold start");
        porPulse("por");
        for (int e = 1; e <= 24; e++) begin
            applyStimulus(1'b1, 1'b0);
            if (e == 9)  checkValue("cold e9 dom", 32'(bus.dom_rst_n), 32'h0);
            if (e == 10) checkValue("cold e10 dom", 32'(bus.dom_rst_n), 32'h1);
            if (e == 14) checkValue("cold e14 dom", 32'(bus.dom_rst_n), 32'h3);
            if (e == 18) checkValue("cold e18 dom", 32'(bus.dom_rst_n), 32'h7);
            if (e == 21) checkValue("cold e21 done", 32'(bus.seq_done), 32'h0);
            if (e == 22) begin
                checkValue("cold e22 dom", 32'(bus.dom_rst_n), 32'hF);
                checkValue("cold e22 done", 32'(bus.seq_done), 32'h1);
            end
        end

        $display("[TB] software reset in RUN");
        applyStimulus(1'b1, 1'b1);
        checkValue("sw E dom", 32'(bus.dom_rst_n), 32'h0);
        checkValue("sw E state", 32'(bus.seq_state), 32'h4);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (k == 2)  checkValue("sw E+2 dom", 32'(bus.dom_rst_n), 32'h0);
            if (k == 3)  checkValue("sw E+3 dom", 32'(bus.dom_rst_n), 32'h1);
            if (k == 7)  checkValue("sw E+7 dom", 32'(bus.dom_rst_n), 32'h3);
            if (k == 14) checkValue("sw E+14 done", 32'(bus.seq_done), 32'h0);
            if (k == 15) begin
                checkValue("sw E+15 dom", 32'(bus.dom_rst_n), 32'hF);
                checkValue("sw E+15 done", 32'(bus.seq_done), 32'h1);
            end
        end

        $display("[TB] repeated request during hold");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkValue("sw2 E+2 dom", 32'(bus.dom_rst_n), 32'h0);
        applyStimulus(1'b1, 1'b0);
        checkValue("sw2 E+3 dom", 32'(bus.dom_rst_n), 32'h1);
        for (int k = 4; k <= 17; k++) applyStimulus(1'b1, 1'b0);

        $display("[TB] lock loss in RUN");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkValue("loss a+1 dom", 32'(bus.dom_rst_n), 32'hF);
        applyStimulus(1'b1, 1'b0);
        checkValue("loss a+2 dom", 32'(bus.dom_rst_n), 32'h0);
        checkValue("loss a+2 done", 32'(bus.seq_done), 32'h0);
        checkValue("loss a+2 state", 32'(bus.seq_state), 32'h1);
        for (int k = 3; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (k == 9)  checkValue("relock a+9 dom", 32'(bus.dom_rst_n), 32'h0);
            if (k == 10) checkValue("relock a+10 dom", 32'(bus.dom_rst_n), 32'h1);
        end

        $display("[TB] lock loss and request together in RELEASE");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkValue("both pre state", 32'(bus.seq_state), 32'h2);
        applyStimulus(1'b0, 1'b1);
        checkValue("both state", 32'(bus.seq_state), 32'h1);
        checkValue("both dom", 32'(bus.dom_rst_n), 32'h0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0);

        $display("[TB] lock chatter");
        porPulse("por2");
        for (int e = 1; e <= 18; e++) begin
            applyStimulus(e != 6, 1'b0);
            if (e == 15) checkValue("chatter e15 dom", 32'(bus.dom_rst_n), 32'h0);
            if (e == 16) checkValue("chatter e16 dom", 32'(bus.dom_rst_n), 32'h1);
        end

        $display("[TB] async reset mid-release");
        #3;
        porPulse("por3");
        for (int e = 1; e <= 24; e++) begin
            applyStimulus(1'b1, 1'b0);
            if (e == 9)  checkValue("recold e9 dom", 32'(bus.dom_rst_n), 32'h0);
            if (e == 10) checkValue("recold e10 dom", 32'(bus.dom_rst_n), 32'h1);
            if (e == 22) checkValue("recold e22 dom", 32'(bus.dom_rst_n), 32'hF);
        end

        $display("[TB] randomized lock/request run");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
